inst_mem_sync: RTL
==================

# inst_mem_sync

Parametrised, synchronous instruction memory that replaces the combinational fetch ROM. It adds a word-serial program-load port with a valid/ready handshake, a registered fetch path with stall hold and branch-flush NOP injection, and a three-state run/load controller. It sits in the IF stage between the PC adder and the IF/ID pipeline register.

## Interface
- ADDR_W, 12, PC / word-address width; DEPTH = 2**ADDR_W words
- DATA_W, 16, instruction width
- NOP_WORD, 16'h6F0F, bubble word injected on flush or while not running (the ISA's unused-ADDI pattern)
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- run_start  in  1  IDLE→RUN without loading; contents are whatever the init file placed
- load_start  in  1  enter LOAD; write pointer restarts at 0
- load_valid  in  1  load_data is valid this cycle
- load_data  in  DATA_W  word to write
- load_last  in  1  qualifies the final load word
- load_ready  out  1  high only in LOAD
- load_count  out  ADDR_W+1  words written by the most recent load
- stall  in  1  hold the fetch output
- flush  in  1  replace the fetch output with NOP_WORD
- PCAdd_pc  in  ADDR_W  fetch address
- M_instruction  out  DATA_W  registered instruction
- inst_valid  out  1  M_instruction is a real fetched word

## Operation
- States: IDLE (reset state), LOAD, RUN.
- IDLE:
  - load_start → LOAD; else run_start → RUN. load_start has priority.
- LOAD:
  - load_ready = 1.
  - On load_valid, write mem[wr_ptr] ← load_data and increment wr_ptr; load_count ← wr_ptr+1.
  - Go to RUN after the accepted word that has load_last = 1, or after the word written at DEPTH-1, whichever comes first. wr_ptr does not wrap.
  - load_start and run_start are ignored in LOAD.
  - load_valid with load_ready = 0 drops the word. The source must hold it until ready.
- RUN:
  - Priority each cycle: load_start > flush > stall > fetch.
  - load_start: go to LOAD; set wr_ptr = 0 and load_count = 0.
  - flush: M_instruction ← NOP_WORD, inst_valid ← 0. Flush wins over a simultaneous stall.
  - stall: hold M_instruction and inst_valid.
  - Otherwise: M_instruction ← mem[PCAdd_pc], inst_valid ← 1.
- Outside RUN: on every edge, M_instruction ← NOP_WORD and inst_valid ← 0.
- Memory array:
  - Not reset; contents survive reset.
  - Written only in LOAD, so fetch-vs-write collision cannot occur.
  - Preloaded by $readmemh when an init file is supplied.
- PCAdd_pc covers exactly DEPTH words, so there is no out-of-range access.

## Timing
- Reset values (asynchronous):
  - state = IDLE, M_instruction = NOP_WORD, inst_valid = 0.
  - load_ready = 0, load_count = 0, wr_ptr = 0.
- Fetch latency:
  - PCAdd_pc sampled at edge N appears on M_instruction after edge N.
  - One word per cycle, no bubbles without stall or flush.
- First fetch: the first edge in RUN produces a valid word, i.e. the edge after the run_start or final-load edge.
- Load throughput: one word per cycle while load_valid = 1.
- load_ready timing:
  - Rises the cycle after load_start.
  - Falls the cycle after the last word.
- load_count is stable from the edge that accepts the last word until the next load_start.
- Reset mid-LOAD: returns to IDLE immediately; words already written remain; load_count = 0.
- Reset mid-RUN: outputs go to NOP/invalid immediately.

## Structure
- Shared package `cpu_pkg`:
  - state enum {IDLE, LOAD, RUN}
  - NOP_WORD default
  - opcode constants
- One natural sub-module: `inst_mem_array`, a single-port synchronous-write / asynchronous-read array parameterised by ADDR_W and DATA_W.
- Controller FSM, write pointer and output register live in the top module.

## Test plan
- Reset then run_start; PCAdd_pc = 0,1,2 on consecutive cycles with preload 0x6141, 0x6242, 0x6313 → M_instruction 0x6141, 0x6242, 0x6313 one cycle later each; inst_valid = 1.
- load_start, then 5 words 0x0141, 0x6242, 0x6313, 0x61F1, 0x1100 with load_last on the 5th → load_count = 5, state RUN; fetch at addr 4 returns 0x1100.
- RUN with stall = 1 for 2 cycles while PCAdd_pc changes 5→6 → M_instruction holds the addr-5 word; after release, the addr-6 word appears next cycle.
- flush and stall asserted together at PCAdd_pc = 6 → M_instruction = 0x6F0F, inst_valid = 0; next cycle with both low → mem[PCAdd_pc].
- Load with ADDR_W = 3 and 8 words, no load_last → auto RUN after the 8th word, load_count = 8; a 9th load_valid is not accepted (load_ready = 0).
- Assert reset after 3 of 5 load words → IDLE, load_ready = 0, load_count = 0; then run_start and fetch at addr 2 → third loaded word.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: IF-stage controller states, the default bubble word
// and the 4-bit major opcodes that sit in the top nibble of every instruction.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Unused-ADDI encoding; the decoder treats it as a no-op bubble.
    localparam logic [15:0] DEFAULT_NOP_WORD = 16'h6F0F;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;

endpackage

// File: rtl/inst_mem_array.sv
// Single-port instruction storage: synchronous write, asynchronous read.
// Contents are never reset so a program survives a CPU reset.
module inst_mem_array #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_mem_sync.sv
// Synchronous IF-stage instruction memory with a word-serial program-load port,
// registered fetch output (stall hold, flush bubble) and an IDLE/LOAD/RUN controller.
module inst_mem_sync
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 12,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_start,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic [ADDR_W:0]   load_count,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] PCAdd_pc,
    output logic [DATA_W-1:0] M_instruction,
    output logic              inst_valid
);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic              last_word;
    logic [DATA_W-1:0] rd_data;

    assign load_ready = (state == ST_LOAD);
    assign wr_en      = load_ready && load_valid;
    // Filling the top word ends the load even without load_last, so wr_ptr never wraps.
    assign last_word  = load_last || (wr_ptr == '1);

    inst_mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_ptr),
        .wr_data(load_data),
        .rd_addr(PCAdd_pc),
        .rd_data(rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end else if (run_start) begin
                    state_next = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (wr_en && last_word) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            load_count <= '0;
        end else if (state == ST_LOAD) begin
            if (wr_en) begin
                wr_ptr     <= wr_ptr + 1'b1;
                load_count <= {1'b0, wr_ptr} + (ADDR_W + 1)'(1);
            end
        end else if (load_start) begin
            wr_ptr     <= '0;
            load_count <= '0;
        end
    end

    // Priority in RUN: load_start > flush > stall > fetch; any non-RUN edge emits a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            M_instruction <= NOP_WORD;
            inst_valid    <= 1'b0;
        end else if ((state != ST_RUN) || load_start || flush) begin
            M_instruction <= NOP_WORD;
            inst_valid    <= 1'b0;
        end else if (!stall) begin
            M_instruction <= rd_data;
            inst_valid    <= 1'b1;
        end
    end

endmodule
